// File: rtl/dff_bank_pkg.sv
// Shared types and helpers for the serial-load register bank.
package dff_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Word index needs at least one bit even for a single-word bank.
   function automatic int sel_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dff_bank_loader_if.sv
// Serial-load control/data bundle between the pin-level loader driver and dff_bank_loader.
interface dff_bank_loader_if
   import dff_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) ();
   localparam int SW = sel_width(DEPTH);

   logic                   start;
   logic [SW-1:0]          word_sel;
   logic                   bit_valid;
   logic                   data_in;
   logic                   commit;
   logic                   busy;
   logic                   done;
   logic                   sel_err;
   logic [DEPTH*WIDTH-1:0] data_out;

   modport master (
      output start, word_sel, bit_valid, data_in, commit,
      input  busy, done, sel_err, data_out
   );

   modport slave (
      input  start, word_sel, bit_valid, data_in, commit,
      output busy, done, sel_err, data_out
   );
endinterface

// File: rtl/dff_bank_word.sv
// One WIDTH-bit register with per-bit write enable; falling-edge clocked, async active-low clear.
module dff_bank_word #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (we[i]) q[i] <= d[i];
         end
      end
   end

endmodule

// File: rtl/dff_bank_loader.sv
// Serial-load register bank: DEPTH words of WIDTH bits filled one bit per clock.
// Optional atomic shadow output stage enabled by defining DFF_BANK_SHADOW_EN.
//
// state  | meaning
// IDLE   | waiting for start; commits applied here
// SHIFT  | capturing serial bits into staging[addr]
// DONE   | one-cycle completion pulse, then back to IDLE
module dff_bank_loader
   import dff_bank_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   dff_bank_loader_if.slave bus
);

   localparam int SW = sel_width(DEPTH);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SHIFT = SHIFT;
   localparam logic [1:0] ST_DONE  = DONE;

   localparam logic [SW:0]   DEPTH_V = (SW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

   logic [1:0]       state;
   logic [SW-1:0]    addr;
   logic [CW-1:0]    cnt;
   logic             sel_err_q;
   logic             shift_wr;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] stage_q [DEPTH];

   assign shift_wr = (state == ST_SHIFT) && bus.bit_valid;
   assign idx      = (MSB_FIRST != 0) ? (CNT_LAST - cnt) : cnt;
   assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         cnt       <= '0;
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if ({1'b0, bus.word_sel} < DEPTH_V) begin
                     addr  <= bus.word_sel;
                     cnt   <= '0;
                     state <= ST_SHIFT;
                  end else begin
                     sel_err_q <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (bus.bit_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) state <= ST_DONE;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy    = (state == ST_SHIFT);
   assign bus.done    = (state == ST_DONE);
   assign bus.sel_err = sel_err_q;

`ifdef DFF_BANK_SHADOW_EN
   // A commit landing mid-load is held and applied as the FSM leaves DONE,
   // so the shadow always receives a complete word.
   logic commit_pending;
   logic shadow_load;

   assign shadow_load = ((state == ST_IDLE) && bus.commit) ||
                        ((state == ST_DONE) && (bus.commit || commit_pending));

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_pending <= 1'b0;
      end else if (state == ST_DONE) begin
         commit_pending <= 1'b0;
      end else if ((state == ST_SHIFT) && bus.commit) begin
         commit_pending <= 1'b1;
      end
   end
`else
   logic unused_commit;
   assign unused_commit = bus.commit;
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      logic [WIDTH-1:0] we_k;
      assign we_k = (shift_wr && (addr == SW'(k))) ? bit_mask : '0;

      dff_bank_word #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (we_k),
         .d     ({WIDTH{bus.data_in}}),
         .q     (stage_q[k])
      );

`ifdef DFF_BANK_SHADOW_EN
      logic [WIDTH-1:0] shadow_q;

      dff_bank_word #(.WIDTH(WIDTH)) u_shadow (
         .clk   (clk),
         .rst_n (rst_n),
         .we    ({WIDTH{shadow_load}}),
         .d     (stage_q[k]),
         .q     (shadow_q)
      );

      assign bus.data_out[k*WIDTH +: WIDTH] = shadow_q;
`else
      assign bus.data_out[k*WIDTH +: WIDTH] = stage_q[k];
`endif
   end

endmodule

// File: tb/tb_dff_bank_loader.sv
// Directed bench for dff_bank_loader: MSB-first 4-word bank and LSB-first 3-word bank.
module tb_dff_bank_loader;

`ifdef DFF_BANK_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   dff_bank_loader_if #(.WIDTH(8), .DEPTH(4)) ifa ();
   dff_bank_loader_if #(.WIDTH(8), .DEPTH(3)) ifb ();

   dff_bank_loader #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   dff_bank_loader #(.WIDTH(8), .DEPTH(3), .MSB_FIRST(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT acts on the falling edge; the bench samples and drives on the rising edge.
   task automatic cyc();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] v;

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      ifa.start = 0; ifa.word_sel = '0; ifa.bit_valid = 0; ifa.data_in = 0; ifa.commit = 0;
      ifb.start = 0; ifb.word_sel = '0; ifb.bit_valid = 0; ifb.data_in = 0; ifb.commit = 0;

      // reset
      @(posedge clk);
      cyc();
      chk("rst_dout_a", 64'(ifa.data_out), 64'h0);
      chk("rst_busy_a", 64'(ifa.busy), 64'h0);
      chk("rst_done_a", 64'(ifa.done), 64'h0);
      chk("rst_dout_b", 64'(ifb.data_out), 64'h0);
      chk("rst_selerr_b", 64'(ifb.sel_err), 64'h0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_dout_a", 64'(ifa.data_out), 64'h0);
      chk("post_rst_busy_a", 64'(ifa.busy), 64'h0);

      // MSB-first load of 0xB2 into word 2
      v = 8'hB2;
      ifa.word_sel = 2'd2; ifa.start = 1;
      cyc();
      ifa.start = 0;
      chk("load_busy_rise", 64'(ifa.busy), 64'h1);
      for (int i = 0; i < 8; i++) begin
         ifa.bit_valid = 1; ifa.data_in = v[7-i];
         cyc();
         if (i == 3)
            chk("load_partial", 64'(ifa.data_out), SHADOW ? 64'h0 : 64'h00B0_0000);
         if (i < 7) begin
            chk("load_busy", 64'(ifa.busy), 64'h1);
            chk("load_done_early", 64'(ifa.done), 64'h0);
         end
      end
      chk("load_done", 64'(ifa.done), 64'h1);
      chk("load_busy_fall", 64'(ifa.busy), 64'h0);
      ifa.bit_valid = 0;
      cyc();
      chk("load_done_pulse", 64'(ifa.done), 64'h0);
      chk("load_precommit", 64'(ifa.data_out), SHADOW ? 64'h0 : 64'h00B2_0000);
      ifa.commit = 1;
      cyc();
      ifa.commit = 0;
      chk("load_commit", 64'(ifa.data_out), 64'h00B2_0000);

      // LSB-first with a 3-cycle gap after bit 4
      ifb.word_sel = 2'd0; ifb.start = 1;
      cyc();
      ifb.start = 0;
      v = 8'h83;
      for (int i = 0; i < 4; i++) begin
         ifb.bit_valid = 1; ifb.data_in = v[i];
         cyc();
      end
      ifb.bit_valid = 0;
      chk("gap_partial", 64'(ifb.data_out), SHADOW ? 64'h0 : 64'h03);
      for (int g = 0; g < 3; g++) begin
         cyc();
         chk("gap_busy", 64'(ifb.busy), 64'h1);
      end
      for (int i = 4; i < 8; i++) begin
         ifb.bit_valid = 1; ifb.data_in = v[i];
         cyc();
      end
      ifb.bit_valid = 0;
      chk("gap_done", 64'(ifb.done), 64'h1);
      ifb.commit = 1;
      cyc();
      ifb.commit = 0;
      chk("gap_word0", 64'(ifb.data_out), 64'h0000_83);

      // 0x5A into word 1, start during SHIFT, commits during bits 5 and 6
      v = 8'h5A;
      ifa.word_sel = 2'd1; ifa.start = 1;
      cyc();
      ifa.start = 0;
      for (int i = 0; i < 8; i++) begin
         ifa.bit_valid = 1; ifa.data_in = v[7-i];
         if (i == 2) begin ifa.start = 1; ifa.word_sel = 2'd3; end
         if (i == 4 || i == 5) ifa.commit = 1;
         cyc();
         ifa.start = 0; ifa.commit = 0;
         if (i == 4)
            chk("defer_mid", 64'(ifa.data_out), SHADOW ? 64'h00B2_0000 : 64'h00B2_5800);
      end
      ifa.bit_valid = 0;
      chk("defer_done", 64'(ifa.done), 64'h1);
      chk("defer_at_done", 64'(ifa.data_out), SHADOW ? 64'h00B2_0000 : 64'h00B2_5A00);
      chk("defer_no_selerr", 64'(ifa.sel_err), 64'h0);
      cyc();
      chk("defer_applied", 64'(ifa.data_out), 64'h00B2_5A00);
      chk("defer_idle", 64'(ifa.busy), 64'h0);
      cyc();
      chk("defer_stable", 64'(ifa.data_out), 64'h00B2_5A00);

      // out-of-range word on the 3-word bank
      ifb.word_sel = 2'd3; ifb.start = 1;
      cyc();
      ifb.start = 0;
      chk("rej_selerr", 64'(ifb.sel_err), 64'h1);
      chk("rej_busy", 64'(ifb.busy), 64'h0);
      cyc();
      chk("rej_selerr_pulse", 64'(ifb.sel_err), 64'h0);
      chk("rej_stay_idle", 64'(ifb.busy), 64'h0);
      chk("rej_dout", 64'(ifb.data_out), 64'h0000_83);

      // reset mid-load, then a clean load of 0xFF into word 3
      v = 8'hC3;
      ifa.word_sel = 2'd0; ifa.start = 1;
      cyc();
      ifa.start = 0;
      for (int i = 0; i < 4; i++) begin
         ifa.bit_valid = 1; ifa.data_in = v[7-i];
         cyc();
      end
      ifa.bit_valid = 0;
      chk("mid_busy_before", 64'(ifa.busy), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(ifa.busy), 64'h0);
      chk("mid_rst_dout", 64'(ifa.data_out), 64'h0);
      chk("mid_rst_dout_b", 64'(ifb.data_out), 64'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      ifa.word_sel = 2'd3; ifa.start = 1;
      cyc();
      ifa.start = 0;
      for (int i = 0; i < 8; i++) begin
         ifa.bit_valid = 1; ifa.data_in = 1'b1;
         cyc();
      end
      ifa.bit_valid = 0;
      chk("ff_done", 64'(ifa.done), 64'h1);
      chk("ff_precommit", 64'(ifa.data_out), SHADOW ? 64'h0 : 64'hFF00_0000);
      cyc();
      ifa.commit = 1;
      cyc();
      ifa.commit = 0;
      chk("ff_commit", 64'(ifa.data_out), 64'hFF00_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
